// File: rtl/propagater_arbiter_if.sv
// Handshake bundle between the arbiter (master) and the shared propagater (slave).
interface propagater_arbiter_if #(
    parameter int unsigned INFO_W = 14,
    parameter int unsigned DIV_W  = 13
);
    logic [INFO_W-1:0] prop_info;
    logic [DIV_W-1:0]  prop_divisor;
    logic              prop_valid;
    logic [INFO_W-1:0] prop_avg;
    logic              prop_ready;

    modport master (
        output prop_info,
        output prop_divisor,
        output prop_valid,
        input  prop_avg,
        input  prop_ready
    );

    modport slave (
        input  prop_info,
        input  prop_divisor,
        input  prop_valid,
        output prop_avg,
        output prop_ready
    );
endinterface

// File: rtl/propagater_arbiter.sv
// Round-robin arbiter sharing one propagater averaging unit among N_REQ requesters,
// with divide-by-zero screening and an ISSUE timeout.
module propagater_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned INFO_W  = 14,
    parameter int unsigned DIV_W   = 13,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*INFO_W-1:0] req_info,
    input  logic [N_REQ*DIV_W-1:0]  req_divisor,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [INFO_W-1:0]       result,
    output logic                    err,
    output logic                    busy,
    propagater_arbiter_if.master    prop
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [INFO_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [INFO_W-1:0] info_q, info_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zdiv_q, zdiv_d;

    logic [INFO_W-1:0] info_arr [N_REQ];
    logic [DIV_W-1:0]  div_arr  [N_REQ];
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [N_REQ-1:0]  pick_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign info_arr[g] = req_info[g*INFO_W +: INFO_W];
        assign div_arr[g]  = req_divisor[g*DIV_W +: DIV_W];
    end

    // First pending requester strictly after rr_q, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((32'(rr_q) + off) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        result_d = result_q;
        err_d    = err_q;
        info_d   = info_q;
        div_d    = div_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        zdiv_d   = zdiv_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    info_d  = info_arr[pick_idx];
                    div_d   = div_arr[pick_idx];
                    grant_d = pick_oh;
                    rr_d    = pick_idx;
                    cnt_d   = '0;
                    // A zero divisor still passes through ISSUE with valid low,
                    // which places its done pulse two cycles after acceptance.
                    zdiv_d  = (div_arr[pick_idx] == '0);
                    valid_d = (div_arr[pick_idx] != '0);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (zdiv_q || prop.prop_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    done_d  = grant_q;
                    state_d = S_DONE;
                    if (!zdiv_q && prop.prop_ready) begin
                        result_d = prop.prop_avg;
                        err_d    = 1'b0;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            info_q   <= '0;
            div_q    <= '0;
            valid_q  <= 1'b0;
            rr_q     <= IDX_W'(N_REQ - 1);
            cnt_q    <= '0;
            zdiv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            info_q   <= info_d;
            div_q    <= div_d;
            valid_q  <= valid_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            zdiv_q   <= zdiv_d;
        end
    end

    assign grant             = grant_q;
    assign done              = done_q;
    assign result            = result_q;
    assign err               = err_q;
    assign busy              = busy_q;
    assign prop.prop_info    = info_q;
    assign prop.prop_divisor = div_q;
    assign prop.prop_valid   = valid_q;
endmodule

// File: doc/propagater_arbiter.md
Name: propagater_arbiter

Overview:
- Shares one propagater averaging unit among N_REQ synapse requesters.
- Selects one pending requester round-robin, latches its info/divisor, drives the propagater valid/ready handshake and routes avg back with a one-cycle done pulse to the granted requester.
- Screens out divide-by-zero requests and recovers from a hung propagater through a timeout.
- Sits between the synapse request array and the single propagater instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- INFO_W, 14, width of info and avg.
- DIV_W, 13, width of divisor.
- TIMEOUT, 64, maximum cycles in ISSUE before abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until that requester's done.
- req_info  in  N_REQ*INFO_W  flattened operands; slice i = bits [i*INFO_W +: INFO_W].
- req_divisor  in  N_REQ*DIV_W  flattened divisors, same slicing.
- grant  out  N_REQ  one-hot owner of the propagater; all zero when idle.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- result  out  INFO_W  average returned; valid only in the cycle done is high.
- err  out  1  high with done when divisor==0 or timeout; result=0 in that case.
- busy  out  1  high whenever state != IDLE.
- prop_info  out  INFO_W  operand to propagater.info.
- prop_divisor  out  DIV_W  operand to propagater.divisor.
- prop_valid  out  1  to propagater.valid.
- prop_avg  in  INFO_W  from propagater.avg.
- prop_ready  in  1  from propagater.ready; the result is taken in the first cycle it is sampled high.

Behaviour:
- Reset (async, immediate):
  - All outputs 0; state=IDLE; rr_ptr=N_REQ-1; timeout counter=0.
  - Reset mid-transaction abandons it: no done is issued, and prop_valid drops immediately.
- States: IDLE, ISSUE, DONE, GAP. All outputs are registered.
- IDLE:
  - If req!=0, pick the first set bit searching upward from rr_ptr+1 with wrap-around.
  - Latch that requester's info/divisor into prop_info/prop_divisor and set grant one-hot.
  - Update rr_ptr to the winner.
  - If the latched divisor==0, go to DONE with err=1 and result=0. prop_valid is never raised.
  - Otherwise go to ISSUE with prop_valid=1 and the timeout counter cleared.
  - If req==0, stay in IDLE.
- ISSUE:
  - prop_valid, prop_info and prop_divisor are held stable; the counter increments each cycle.
  - If prop_ready=1: register result=prop_avg and err=0, then go to DONE.
  - Else if counter==TIMEOUT-1: result=0, err=1, go to DONE.
  - prop_ready takes priority when it coincides with the final timeout cycle.
- DONE (one cycle):
  - done[g]=1 for the granted index g; result/err are valid; prop_valid=0; grant is still asserted.
  - Always go to GAP.
- GAP (one cycle):
  - grant=0, done=0, prop_valid=0. This guarantees the propagater sees valid low between transactions.
  - Go to IDLE.
- Latency:
  - Request accepted in IDLE at cycle t: prop_valid rises at t+1.
  - prop_ready sampled at cycle r: done at r+1.
  - Next grant occurs no earlier than r+3.
  - Divisor==0 request: done at t+2.
- Fairness: rr_ptr advances only on a grant. A continuously requesting requester waits at most N_REQ-1 transactions.
- A requester that drops req while granted: the transaction still completes and done still pulses; the requester ignores it.
- Changes to req_info/req_divisor after grant have no effect, because operands are latched.
- prop_ready outside ISSUE is ignored.
- result and err hold their last value after DONE; consumers qualify them with done.
- Simultaneous requests in IDLE: exactly one grant, chosen by the round-robin rule.

Test Plan:
- Single request: req=0001, info0=27, divisor0=9; propagater model gives avg=info/divisor after 3 cycles -> prop_valid high for 4 cycles, done=0001 with result=3, err=0; grant=0 in the GAP cycle.
- Contention: req=1111 held, all divisors=2, info_i=10*(i+1), starting from reset -> done order 0,1,2,3,0 with results 5,10,15,20,5.
- Divisor zero: req=0100, divisor2=0, info2=100 -> prop_valid never rises, done=0100 two cycles after acceptance, err=1, result=0.
- Timeout: model never raises ready, TIMEOUT=64, req=0010 -> done=0010 exactly 64 cycles after prop_valid rose, err=1, result=0; the next request is served normally.
- Reset mid-operation: assert reset 2 cycles into ISSUE -> grant, prop_valid and done drop to 0 asynchronously and no done pulse follows; after release, req=0001 with info=27, divisor=9 gives result=3.
- Ready on the final timeout cycle: ready arrives in ISSUE cycle 64 with avg=7 -> done with result=7, err=0.
